calc_seq_ctrl: RTL and testbench
================================

# calc_seq_ctrl

Sequencing controller for the four-function calculator datapath. It turns debounced, active-low operation keys into single operation requests and latches the switch operands for the combinational `modCalc` ALU. It waits a fixed ALU settling time, then captures the result and pulses completion. It sits between the `debounce` instances and `modCalc`/`display7seg`. It replaces the negedge-of-AND key logic with a single-clock FSM.

## Interface
Parameters:
- `W`, 4, operand/result width in bits.
- `ALU_LAT`, 1, cycles to wait after driving the ALU before sampling its result. Legal range is 1..15.

Ports:
- `CLK_28`  in  1  system clock; all state updates on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `key_n`  in  4  debounced keys, active low: bit0 add, bit1 sub, bit2 mul, bit3 div.
- `sw_a`  in  W  operand A from switches.
- `sw_b`  in  W  operand B from switches.
- `alu_s`  in  W  ALU result, combinational from `alu_a/alu_b/alu_op`.
- `alu_a`  out  W  registered operand A to the ALU.
- `alu_b`  out  W  registered operand B to the ALU.
- `alu_op`  out  2  registered opcode: 0 add, 1 sub, 2 mul, 3 div.
- `result`  out  W  last captured result.
- `busy`  out  1  high while in WAIT.
- `done`  out  1  one-cycle pulse when `result` updates.
- `div0`  out  1  sticky flag: last operation was a divide by zero.
- `op_count`  out  8  number of completed operations.

## Operation
- Key edge detect:
  - `key_q` holds `key_n` delayed by one cycle.
  - A press is `key_q[i]==1 && key_n[i]==0`.
  - Holding a key produces exactly one press.
- Simultaneous presses in the same cycle: the lowest index wins (add > sub > mul > div). The other presses are discarded.
- FSM states:
  - IDLE:
    - On a press, latch `alu_a<=sw_a`, `alu_b<=sw_b` and `alu_op<=`the winning index.
    - Clear `div0` and load the wait counter with `ALU_LAT`.
    - Go to WAIT.
    - Exception: for div with `sw_b==0`, go to CAPTURE instead (see Configuration).
  - WAIT:
    - The counter decrements each cycle.
    - When it reaches 1, go to CAPTURE.
    - Presses seen in WAIT are ignored and not queued.
  - CAPTURE:
    - Set `result<=alu_s`, or all-ones for a divide by zero.
    - Assert `done` for this cycle only.
    - Increment `op_count` modulo 256 (255 wraps to 0).
    - Return to IDLE.
    - Presses seen in CAPTURE are also ignored.
- `alu_a`, `alu_b` and `alu_op` hold their values until the next accepted press, so the displays stay stable.
- Width rule: `result` is the W LSBs of `alu_s`. The block does no overflow detection.

## Timing
- Reset values:
  - state IDLE
  - `key_q` = 4'b0000, so a key held through reset never fires until it is released and pressed again
  - `alu_a`, `alu_b`, `alu_op`, `result`, `op_count` = 0
  - `busy`, `done`, `div0` = 0
- A press sampled at edge N:
  - ALU inputs are valid after edge N.
  - `busy` is high for cycles N+1 .. N+ALU_LAT.
  - `result`, `done` and `op_count` update at edge N+ALU_LAT+1.
  - `done` falls at edge N+ALU_LAT+2.
- Divide by zero (feature enabled): `result`, `done` and `div0` update at edge N+1. `busy` never rises.
- The earliest next accepted press is the cycle after CAPTURE.
- Reset asserted mid-operation:
  - All state returns to the reset values immediately (asynchronously).
  - No `done` pulse is issued.
  - The pending operation is lost.

## Configuration
- `CALC_SEQ_DIV0_EN` defined:
  - Div with `sw_b==0` bypasses WAIT.
  - `result` is forced to all-ones (4'hF for W=4).
  - `div0` is set and stays set until the next accepted press.
- Not defined:
  - Divide by zero is sequenced like any other operation and `result` takes `alu_s`.
  - `div0` is tied to 0.

## Test plan
- Reset with `key_n[0]` held low, then release reset -> no `done`. Release and re-press -> `alu_op=0`, and with `sw_a=3`, `sw_b=4`, `result=7` and `done` at N+ALU_LAT+1.
- Press sub and mul in the same cycle with `sw_a=9`, `sw_b=2` -> `alu_op=1`, `result=7`, a single `done`, `op_count` +1.
- Press mul, then press add during WAIT (ALU_LAT=3) -> the add is ignored, `result=`mul value, exactly one `done`.
- Div with `sw_a=8`, `sw_b=0`:
  - with the macro -> `result=4'hF`, `div0=1`, `done` at N+1
  - then add 1+1 -> `div0=0`, `result=2`
- Issue 257 operations -> `op_count=1`. Assert `RST_N` during WAIT -> all outputs are 0 and no `done` is issued.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: key edge detect, operand latch, ALU settle wait, result capture.
// Optional divide-by-zero bypass is enabled by defining CALC_SEQ_DIV0_EN.
module calc_seq_ctrl #(
   parameter int W       = 4,
   parameter int ALU_LAT = 1
) (
   input  logic         CLK_28,
   input  logic         RST_N,
   input  logic [3:0]   key_n,
   input  logic [W-1:0] sw_a,
   input  logic [W-1:0] sw_b,
   input  logic [W-1:0] alu_s,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   output logic [W-1:0] result,
   output logic         busy,
   output logic         done,
   output logic         div0,
   output logic [7:0]   op_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   localparam logic [3:0] LAT = 4'(ALU_LAT);

   state_t     state, state_nx;
   logic [3:0] key_q;
   logic [3:0] press;
   logic [1:0] win_op;
   logic [3:0] wait_cnt;
   logic       accept;
   logic       bypass;
   logic       cap_div0;

   assign press  = key_q & ~key_n;
   assign accept = (state == S_IDLE) && (press != 4'b0000);
   assign busy   = (state == S_WAIT);

   // Lowest key index wins when several presses land in the same cycle.
   always_comb begin
      win_op = 2'd0;
      if (press[0])      win_op = 2'd0;
      else if (press[1]) win_op = 2'd1;
      else if (press[2]) win_op = 2'd2;
      else if (press[3]) win_op = 2'd3;
   end

`ifdef CALC_SEQ_DIV0_EN
   assign bypass   = accept && (win_op == 2'd3) && (sw_b == '0);
   assign cap_div0 = (alu_op == 2'd3) && (alu_b == '0);

   always_ff @(posedge CLK_28 or negedge RST_N) begin
      if (!RST_N)
         div0 <= 1'b0;
      else if (accept)
         div0 <= 1'b0;
      else if (state == S_CAPTURE && cap_div0)
         div0 <= 1'b1;
   end
`else
   assign bypass   = 1'b0;
   assign cap_div0 = 1'b0;
   assign div0     = 1'b0;
`endif

   always_ff @(posedge CLK_28 or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch is inferred.
      state_nx = state;
      case (state)
         S_IDLE:    if (accept) state_nx = bypass ? S_CAPTURE : S_WAIT;
         S_WAIT:    if (wait_cnt == 4'd1) state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_28 or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: key_q resets to 0 so a key held through reset cannot fire until released.
         key_q    <= 4'b0000;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= 2'd0;
         result   <= '0;
         done     <= 1'b0;
         op_count <= 8'd0;
         wait_cnt <= 4'd0;
      end else begin
         key_q <= key_n;
         done  <= 1'b0;
         if (accept) begin
            alu_a    <= sw_a;
            alu_b    <= sw_b;
            alu_op   <= win_op;
            wait_cnt <= LAT;
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (state == S_CAPTURE) begin
            result   <= cap_div0 ? '1 : alu_s;
            done     <= 1'b1;
            op_count <= op_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: vector table, corner sequences and random keys
// checked against an edge-timestamp reference model.
module tb_calc_seq_ctrl;

   localparam int W   = 4;
   localparam int LAT = 3;
`ifdef CALC_SEQ_DIV0_EN
   localparam bit DIV0_EN = 1'b1;
`else
   localparam bit DIV0_EN = 1'b0;
`endif

   logic         CLK_28 = 1'b0;
   logic         RST_N  = 1'b0;
   logic [3:0]   key_n  = 4'hF;
   logic [W-1:0] sw_a   = '0;
   logic [W-1:0] sw_b   = '0;
   logic [W-1:0] alu_s;
   logic [W-1:0] alu_a, alu_b, result;
   logic [1:0]   alu_op;
   logic         busy, done, div0;
   logic [7:0]   op_count;

   calc_seq_ctrl #(.W(W), .ALU_LAT(LAT)) dut (
      .CLK_28(CLK_28), .RST_N(RST_N), .key_n(key_n), .sw_a(sw_a), .sw_b(sw_b),
      .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .result(result),
      .busy(busy), .done(done), .div0(div0), .op_count(op_count)
   );

   always #5 CLK_28 = ~CLK_28;

   // Stand-in for the modCalc ALU; divide by zero yields 0.
   function automatic logic [W-1:0] alu_ref(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a * b;
         default: return (b == '0) ? '0 : a / b;
      endcase
   endfunction

   assign alu_s = alu_ref(alu_op, alu_a, alu_b);

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Reference model: tracks accept/done edges as timestamps.
   int           ready_edge = 0;
   int           done_edge  = -1;
   int           acc_edge   = -100;
   logic [3:0]   m_kprev    = 4'b0000;
   logic         m_pend_div0 = 1'b0;
   logic [W-1:0] m_a = '0, m_b = '0, m_res = '0, m_pend = '0;
   logic [1:0]   m_op = 2'd0;
   logic         m_div0 = 1'b0;
   logic [7:0]   m_cnt = 8'd0;

   task automatic model_reset();
      ready_edge  = 0;
      done_edge   = -1;
      acc_edge    = -100;
      m_kprev     = 4'b0000;
      m_pend_div0 = 1'b0;
      m_a = '0; m_b = '0; m_res = '0; m_pend = '0;
      m_op = 2'd0; m_div0 = 1'b0; m_cnt = 8'd0;
   endtask

   task automatic model_edge();
      logic [3:0] p;
      int         op_i;
      p = m_kprev & ~key_n;
      edge_n++;
      if (edge_n == done_edge) begin
         m_res  = m_pend;
         m_cnt  = m_cnt + 8'd1;
         m_div0 = m_pend_div0;
      end
      if (edge_n >= ready_edge && p != 4'b0000) begin
         op_i = 0;
         for (int i = 3; i >= 0; i--) if (p[i]) op_i = i;
         m_a         = sw_a;
         m_b         = sw_b;
         m_op        = 2'(op_i);
         m_div0      = 1'b0;
         m_pend_div0 = DIV0_EN && (op_i == 3) && (sw_b == '0);
         m_pend      = m_pend_div0 ? '1 : alu_ref(m_op, sw_a, sw_b);
         acc_edge    = edge_n;
         done_edge   = edge_n + (m_pend_div0 ? 1 : LAT + 1);
         ready_edge  = done_edge + 1;
      end
      m_kprev = key_n;
   endtask

   task automatic compare_all();
      logic eb;
      eb = !m_pend_div0 && (edge_n >= acc_edge) && (edge_n < acc_edge + LAT);
      check("alu_a",    32'(alu_a),    32'(m_a));
      check("alu_b",    32'(alu_b),    32'(m_b));
      check("alu_op",   32'(alu_op),   32'(m_op));
      check("result",   32'(result),   32'(m_res));
      check("busy",     32'(busy),     32'(eb));
      check("done",     32'(done),     32'(edge_n == done_edge));
      check("div0",     32'(div0),     32'(m_div0));
      check("op_count", 32'(op_count), 32'(m_cnt));
   endtask

   task automatic step(input logic [3:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
      key_n = k;
      sw_a  = a;
      sw_b  = b;
      @(posedge CLK_28);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      RST_N = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(posedge CLK_28);
      #1;
      RST_N = 1'b1;
   endtask

   // Release, press, then wait (bounded) for done; lat = edges from press to done.
   task automatic run_op(input logic [3:0] k, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      step(4'hF, a, b);
      step(k, a, b);
      for (int i = 1; i <= 40 && !got; i++) begin
         step(4'hF, a, b);
         if (done) begin
            got = 1'b1;
            lat = i;
         end
      end
      check("done_seen", 32'(got), 32'd1);
   endtask

   typedef struct {
      logic [3:0]   key;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic [W-1:0] res;
      int           lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int lat;
      int dones;

      vecs[0] = '{4'b1110, 4'd3,  4'd4, 2'd0, 4'd7,  LAT + 1};
      vecs[1] = '{4'b1001, 4'd9,  4'd2, 2'd1, 4'd7,  LAT + 1};
      vecs[2] = '{4'b1011, 4'd3,  4'd5, 2'd2, 4'd15, LAT + 1};
      vecs[3] = '{4'b1011, 4'd5,  4'd5, 2'd2, 4'd9,  LAT + 1};
      vecs[4] = '{4'b1101, 4'd2,  4'd5, 2'd1, 4'd13, LAT + 1};
      vecs[5] = '{4'b0111, 4'd9,  4'd2, 2'd3, 4'd4,  LAT + 1};
      vecs[6] = '{4'b1110, 4'd15, 4'd1, 2'd0, 4'd0,  LAT + 1};
      vecs[7] = '{4'b0111, 4'd8,  4'd0, 2'd3, DIV0_EN ? 4'hF : 4'h0, DIV0_EN ? 1 : LAT + 1};
      vecs[8] = '{4'b0000, 4'd6,  4'd3, 2'd0, 4'd9,  LAT + 1};

      // Add key held through reset must not fire.
      key_n = 4'b1110;
      apply_reset();
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         step(4'b1110, 4'd3, 4'd4);
         dones += int'(done);
      end
      check("held_key_no_done", 32'(dones), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].key, vecs[i].a, vecs[i].b, lat);
         check("vec_result", 32'(result), 32'(vecs[i].res));
         check("vec_op",     32'(alu_op), 32'(vecs[i].op));
         check("vec_lat",    32'(lat),    32'(vecs[i].lat));
         check("vec_count",  32'(op_count), 32'(i + 1));
         if (i == 7) check("div0_flag", 32'(div0), 32'(DIV0_EN));
      end

      // Div 8/0 followed by add 1+1 clears div0.
      run_op(4'b0111, 4'd8, 4'd0, lat);
      run_op(4'b1110, 4'd1, 4'd1, lat);
      check("div0_cleared", 32'(div0), 32'd0);
      check("add_after_div0", 32'(result), 32'd2);

      // Mul, then add pressed during WAIT: only the mul completes.
      dones = 0;
      step(4'hF, 4'd3, 4'd5);
      step(4'b1011, 4'd3, 4'd5);
      step(4'b1011, 4'd3, 4'd5);
      step(4'b1110, 4'd1, 4'd1);
      dones += int'(done);
      for (int i = 0; i < 10; i++) begin
         step(i < 6 ? 4'b1110 : 4'hF, 4'd1, 4'd1);
         dones += int'(done);
      end
      check("wait_press_dones", 32'(dones), 32'd1);
      check("wait_press_result", 32'(result), 32'd15);
      check("wait_press_op", 32'(alu_op), 32'd2);

      // Random keys and operands.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 4'($urandom),
              ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom));
      end

      // 257 operations wrap op_count to 1.
      apply_reset();
      for (int i = 0; i < 257; i++) run_op(4'b1110, 4'(i), 4'd1, lat);
      check("op_count_wrap", 32'(op_count), 32'd1);

      // Reset during WAIT: outputs clear at once, no done afterwards.
      step(4'hF, 4'd7, 4'd3);
      step(4'b1011, 4'd7, 4'd3);
      step(4'hF, 4'd7, 4'd3);
      check("busy_before_rst", 32'(busy), 32'd1);
      key_n = 4'hF;
      apply_reset();
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step(4'hF, 4'd7, 4'd3);
         dones += int'(done);
      end
      check("rst_no_done", 32'(dones), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
